// File: rtl/cmp_zelg_seq.sv
// ---------------------------------------------------------------------------
// cmp_zelg_seq
//   Multi-cycle zero/equal/less/greater comparator. Two p_WIDTH operands are
//   compared MSB-first, p_DIGIT bits per cycle, stopping at the first chunk
//   that differs. With p_SIGNED=1 the sign bits are inverted at capture
//   (offset binary), so a plain unsigned chunk compare gives the signed order.
//
// Ports
//   CLK        in   1        clock, all state on rising edge
//   RST_N      in   1        asynchronous active-low reset
//   i_start    in   1        request, accepted only in IDLE or DONE
//   i_x        in   p_WIDTH  operand X, captured on accepted start
//   i_y        in   p_WIDTH  operand Y, captured on accepted start
//   o_busy     out  1        high while a compare is running
//   o_done     out  1        one-cycle pulse, result flags updated
//   o_zero     out  1        captured X was zero
//   o_eq       out  1        X == Y
//   o_less     out  1        X <  Y
//   o_greater  out  1        X >  Y
// ---------------------------------------------------------------------------
module cmp_zelg_seq #(
    parameter int p_WIDTH  = 8,
    parameter int p_DIGIT  = 2,
    parameter int p_SIGNED = 0
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               i_start,
    input  logic [p_WIDTH-1:0] i_x,
    input  logic [p_WIDTH-1:0] i_y,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_zero,
    output logic               o_eq,
    output logic               o_less,
    output logic               o_greater
);

    localparam int NCHUNK = (p_WIDTH + p_DIGIT - 1) / p_DIGIT;
    localparam int EXT_W  = NCHUNK * p_DIGIT;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NCHUNK - 1);
    localparam logic [IDX_W-1:0]   ONE_IDX   = IDX_W'(1);
    localparam logic [IDX_W-1:0]   ZERO_IDX  = IDX_W'(0);
    localparam logic [p_WIDTH-1:0] SIGN_MASK = p_WIDTH'(1) << (p_WIDTH - 1);
    localparam logic [p_WIDTH-1:0] ZERO_OP   = p_WIDTH'(0);
    localparam logic [EXT_W-1:0]   ZERO_EXT  = EXT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Map an operand into the compare domain: optional sign-bit flip, then
    // zero-extension so the top chunk is padded with zeros at its MSB side.
    function automatic logic [EXT_W-1:0] to_ext(input logic [p_WIDTH-1:0] v);
        logic [p_WIDTH-1:0] t;
        if (p_SIGNED != 0) begin
            t = v ^ SIGN_MASK;
        end else begin
            t = v;
        end
        return EXT_W'(t);
    endfunction

    // Extract chunk number idx (chunk 0 holds the LSBs).
    function automatic logic [p_DIGIT-1:0] chunk_of(input logic [EXT_W-1:0] v,
                                                    input logic [IDX_W-1:0] idx);
        return p_DIGIT'(v >> (int'(idx) * p_DIGIT));
    endfunction

    state_t             state_r;
    logic [EXT_W-1:0]   x_r;
    logic [EXT_W-1:0]   y_r;
    logic [IDX_W-1:0]   idx_r;
    logic               zero_pend_r;

    logic [p_DIGIT-1:0] x_chunk_s;
    logic [p_DIGIT-1:0] y_chunk_s;
    logic               gt_s;
    logic               lt_s;
    logic               last_s;
    logic               start_ok_s;

    // Current-chunk compare and start acceptance.
    always_comb begin
        x_chunk_s  = chunk_of(x_r, idx_r);
        y_chunk_s  = chunk_of(y_r, idx_r);
        gt_s       = (x_chunk_s > y_chunk_s);
        lt_s       = (x_chunk_s < y_chunk_s);
        last_s     = (idx_r == ZERO_IDX);
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            start_ok_s = i_start;
        end else begin
            start_ok_s = 1'b0;
        end
    end

    // Control FSM, operand/index registers and registered result flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r     <= ST_IDLE;
            x_r         <= ZERO_EXT;
            y_r         <= ZERO_EXT;
            idx_r       <= ZERO_IDX;
            zero_pend_r <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_zero      <= 1'b0;
            o_eq        <= 1'b0;
            o_less      <= 1'b0;
            o_greater   <= 1'b0;
        end else if (start_ok_s) begin
            // Capture; flags keep their previous result until the next done.
            state_r     <= ST_RUN;
            x_r         <= to_ext(i_x);
            y_r         <= to_ext(i_y);
            idx_r       <= LAST_IDX;
            zero_pend_r <= (i_x == ZERO_OP);
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    o_busy <= 1'b0;
                    o_done <= 1'b0;
                end
                ST_RUN: begin
                    if (gt_s || lt_s || last_s) begin
                        state_r   <= ST_DONE;
                        o_busy    <= 1'b0;
                        o_done    <= 1'b1;
                        o_zero    <= zero_pend_r;
                        o_greater <= gt_s;
                        o_less    <= lt_s;
                        o_eq      <= ~(gt_s | lt_s);
                    end else begin
                        idx_r <= idx_r - ONE_IDX;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    o_done  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_zelg_seq.sv
// ---------------------------------------------------------------------------
// tb_cmp_zelg_seq
//   Scoreboard bench for cmp_zelg_seq. Three instances:
//     A: p_WIDTH=8, p_DIGIT=2, unsigned
//     S: p_WIDTH=8, p_DIGIT=2, signed
//     O: p_WIDTH=7, p_DIGIT=3, unsigned (exhaustive against a reference)
//   Drivers push {zero,eq,less,greater} plus the expected done cycle into a
//   queue per instance; a monitor per instance pops on every o_done.
// ---------------------------------------------------------------------------
module tb_cmp_zelg_seq;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    // Cycle counter: value after edge n is n.
    always @(posedge CLK) cyc <= cyc + 1;

    logic       a_start = 1'b0, s_start = 1'b0, o_start = 1'b0;
    logic [7:0] a_x = 8'd0, a_y = 8'd0, s_x = 8'd0, s_y = 8'd0;
    logic [6:0] o_x = 7'd0, o_y = 7'd0;
    logic a_busy, a_done, a_zero, a_eq, a_less, a_gt;
    logic s_busy, s_done, s_zero, s_eq, s_less, s_gt;
    logic o_busy, o_done, o_zero, o_eq, o_less, o_gt;

    cmp_zelg_seq #(.p_WIDTH(8), .p_DIGIT(2), .p_SIGNED(0)) u_a (
        .CLK(CLK), .RST_N(RST_N), .i_start(a_start), .i_x(a_x), .i_y(a_y),
        .o_busy(a_busy), .o_done(a_done), .o_zero(a_zero), .o_eq(a_eq),
        .o_less(a_less), .o_greater(a_gt));

    cmp_zelg_seq #(.p_WIDTH(8), .p_DIGIT(2), .p_SIGNED(1)) u_s (
        .CLK(CLK), .RST_N(RST_N), .i_start(s_start), .i_x(s_x), .i_y(s_y),
        .o_busy(s_busy), .o_done(s_done), .o_zero(s_zero), .o_eq(s_eq),
        .o_less(s_less), .o_greater(s_gt));

    cmp_zelg_seq #(.p_WIDTH(7), .p_DIGIT(3), .p_SIGNED(0)) u_o (
        .CLK(CLK), .RST_N(RST_N), .i_start(o_start), .i_x(o_x), .i_y(o_y),
        .o_busy(o_busy), .o_done(o_done), .o_zero(o_zero), .o_eq(o_eq),
        .o_less(o_less), .o_greater(o_gt));

    typedef struct {
        logic [3:0] f;   // {zero, eq, less, greater}
        int         c;   // cycle count at which o_done must be seen
    } exp_t;

    exp_t q_a[$];
    exp_t q_s[$];
    exp_t q_o[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor for A: compare result, latency and busy on every done pulse.
    always @(negedge CLK) begin
        if (RST_N && a_done) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_a.pop_front();
                check("a_flags", {28'd0, a_zero, a_eq, a_less, a_gt}, {28'd0, e.f});
                check("a_latency", cyc, e.c);
                check("a_busy_at_done", {31'd0, a_busy}, 32'd0);
            end
        end
    end

    // Monitor for S.
    always @(negedge CLK) begin
        if (RST_N && s_done) begin
            if (q_s.size() == 0) begin
                check("s_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_s.pop_front();
                check("s_flags", {28'd0, s_zero, s_eq, s_less, s_gt}, {28'd0, e.f});
                check("s_latency", cyc, e.c);
            end
        end
    end

    // Monitor for O.
    always @(negedge CLK) begin
        if (RST_N && o_done) begin
            if (q_o.size() == 0) begin
                check("o_unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q_o.pop_front();
                check("o_flags", {28'd0, o_zero, o_eq, o_less, o_gt}, {28'd0, e.f});
                check("o_latency", cyc, e.c);
            end
        end
    end

    task automatic drive(input int sel, input logic st, input logic [7:0] x, input logic [7:0] y);
        case (sel)
            0: begin a_start = st; a_x = x; a_y = y; end
            1: begin s_start = st; s_x = x; s_y = y; end
            default: begin o_start = st; o_x = x[6:0]; o_y = y[6:0]; end
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            0: return a_done;
            1: return s_done;
            default: return o_done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            0: return a_busy;
            1: return s_busy;
            default: return o_busy;
        endcase
    endfunction

    task automatic push(input int sel, input logic [3:0] f, input int c);
        exp_t e;
        e.f = f;
        e.c = c;
        case (sel)
            0: q_a.push_back(e);
            1: q_s.push_back(e);
            default: q_o.push_back(e);
        endcase
    endtask

    // Wait (bounded) for a done pulse; returns at the negedge where it is seen.
    task automatic wait_done(input int sel);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge CLK);
            seen = get_done(sel);
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    // Issue one operation (caller is at a negedge, DUT in IDLE or DONE).
    task automatic run_op(input int sel, input logic [7:0] x, input logic [7:0] y,
                          input logic [3:0] f, input int k);
        drive(sel, 1'b1, x, y);
        @(posedge CLK);
        #1;
        push(sel, f, cyc + k);
        if (sel != 2) check("busy_after_start", {31'd0, get_busy(sel)}, 32'd1);
        drive(sel, 1'b0, x, y);
        wait_done(sel);
    endtask

    // Independent reference for the 7-bit / 3-bit-digit instance.
    task automatic ref7(input int x, input int y, output logic [3:0] f, output int k);
        int d;
        int p;
        f[3] = (x == 0);
        f[2] = (x == y);
        f[1] = (x < y);
        f[0] = (x > y);
        d = x ^ y;
        if (d == 0) begin
            k = 3;
        end else begin
            p = 0;
            for (int b = 0; b < 7; b++) if (d[b]) p = b;
            k = 3 - (p / 3);
        end
    endtask

    initial begin
        logic [3:0] f7;
        int         k7;
        int         guard;

        // Reset state.
        #1;
        check("a_reset_outputs", {26'd0, a_busy, a_done, a_zero, a_eq, a_less, a_gt}, 32'd0);
        check("s_reset_outputs", {26'd0, s_busy, s_done, s_zero, s_eq, s_less, s_gt}, 32'd0);
        check("o_reset_outputs", {26'd0, o_busy, o_done, o_zero, o_eq, o_less, o_gt}, 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("a_idle_no_start", {26'd0, a_busy, a_done, a_zero, a_eq, a_less, a_gt}, 32'd0);

        // Unsigned instance: early exit, full scans, zero flag.
        run_op(0, 8'hC0, 8'h40, 4'b0001, 1);
        run_op(0, 8'h5A, 8'h5A, 4'b0100, 4);
        run_op(0, 8'h00, 8'h00, 4'b1100, 4);
        run_op(0, 8'hFF, 8'h01, 4'b0001, 1);
        run_op(0, 8'h12, 8'h13, 4'b0010, 4);
        run_op(0, 8'h00, 8'h80, 4'b1010, 1);
        // Back-to-back: second start lands in the DONE cycle of the first.
        run_op(0, 8'hC0, 8'h40, 4'b0001, 1);
        run_op(0, 8'h03, 8'h07, 4'b0010, 3);

        // Start held through RUN with operands changing: single result.
        @(negedge CLK);
        @(negedge CLK);
        drive(0, 1'b1, 8'h12, 8'h13);
        @(posedge CLK);
        #1;
        push(0, 4'b0010, cyc + 4);
        drive(0, 1'b1, 8'hFF, 8'h00);
        repeat (3) begin
            @(posedge CLK);
            #1;
            check("a_busy_held_start", {31'd0, a_busy}, 32'd1);
        end
        @(posedge CLK);
        #1;
        drive(0, 1'b0, 8'h00, 8'h00);
        wait_done(0);
        repeat (4) @(negedge CLK);
        check("a_idle_after_held", {31'd0, a_busy}, 32'd0);

        // Signed instance.
        run_op(1, 8'hFF, 8'h01, 4'b0010, 1);
        run_op(1, 8'h80, 8'h7F, 4'b0010, 1);
        run_op(1, 8'h00, 8'hFF, 4'b1001, 1);
        run_op(1, 8'h00, 8'h00, 4'b1100, 4);
        run_op(1, 8'h7F, 8'h7E, 4'b0001, 4);

        // Abort mid-RUN: flags set by a prior greater must clear, no done.
        @(negedge CLK);
        run_op(0, 8'hC0, 8'h40, 4'b0001, 1);
        @(negedge CLK);
        drive(0, 1'b1, 8'h5A, 8'h5A);
        @(posedge CLK);
        #1;
        drive(0, 1'b0, 8'h5A, 8'h5A);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("a_abort_outputs", {26'd0, a_busy, a_done, a_zero, a_eq, a_less, a_gt}, 32'd0);
        repeat (2) @(posedge CLK);
        #2;
        RST_N = 1'b1;
        repeat (6) @(negedge CLK);
        check("a_after_abort", {26'd0, a_busy, a_done, a_zero, a_eq, a_less, a_gt}, 32'd0);

        // Odd width, exhaustive, issued back-to-back.
        for (int x = 0; x < 128; x++) begin
            for (int y = 0; y < 128; y++) begin
                ref7(x, y, f7, k7);
                run_op(2, 8'(x), 8'(y), f7, k7);
            end
        end

        // Drain scoreboards.
        guard = 0;
        while ((q_a.size() + q_s.size() + q_o.size()) != 0 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        check("scoreboard_drained", q_a.size() + q_s.size() + q_o.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
